nonce_sweeper: RTL

//  Upstream driver of the sha256 stage. Sweeps a 32-bit nonce range over a latched header tail.

---
 rtl/miner_pkg.sv | 36 +++
 rtl/nonce_delay_line.sv | 55 +++++
 rtl/nonce_sweeper.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared types and helpers for the nonce sweep front end of the sha256 miner.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package miner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] SHA_PAD_WORD = 32'h8000_0000;
  localparam logic [63:0] HDR_BITLEN   = 64'd640;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Digest comes out of sha256 in wire byte order; the target compares as a
  // little-endian 256-bit number, so the bytes are reversed before comparing.
  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = x[8*(31-i) +: 8];
    end
    return r;
  endfunction

  // Second 64-byte chunk of the 80-byte header: tail, nonce, pad bit, length.
  function automatic logic [511:0] build_tail_block(input logic [95:0] tail,
                                                    input logic [31:0] nonce);
    return {tail, bswap32(nonce), SHA_PAD_WORD, 288'b0, HDR_BITLEN};
  endfunction

endpackage

// File: rtl/nonce_delay_line.sv
// Tag pipe that carries {valid, nonce} alongside the sha256 hash latency.
// Latency: LAT cycles (LAT=0 passes the current issue straight through).
// Backpressure: none; shifts every cycle, synchronous flush clears all stages.
module nonce_delay_line #(
  parameter int LAT     = 0,
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_vld,
  input  logic [NONCE_W-1:0] in_nonce,
  output logic               out_vld,
  output logic [NONCE_W-1:0] out_nonce,
  output logic               pend
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, flush};
      assign out_vld    = in_vld;
      assign out_nonce  = in_nonce;
      assign pend       = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0]     vld_q;
      logic [NONCE_W-1:0] nonce_q [LAT];

      // Shift the tags one stage per cycle; reset or flush empties every stage.
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) nonce_q[i] <= '0;
        end else begin
          vld_q[0]   <= in_vld;
          nonce_q[0] <= in_nonce;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i]   <= vld_q[i-1];
            nonce_q[i] <= nonce_q[i-1];
          end
        end
      end

      // Entries still travelling behind the one being compared this cycle.
      always_comb begin
        pend = 1'b0;
        for (int i = 0; i < LAT - 1; i++) pend = pend | vld_q[i];
      end

      assign out_vld   = vld_q[LAT-1];
      assign out_nonce = nonce_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/nonce_sweeper.sv
// Sweeps a nonce range, issuing one sha256 tail block per cycle and checking returned hashes.
// Latency: first block one cycle after start; each result checked LAT cycles after its issue.
// Backpressure: none; sha256 accepts a block every cycle, issue stops on first hit or abort.
module nonce_sweeper
  import miner_pkg::*;
#(
  parameter int LAT     = 0,
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [95:0]        header_tail,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic [255:0]       target,
  output logic [511:0]       msg_block,
  output logic               msg_valid,
  input  logic [255:0]       hash_in,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce
);

  state_t             state_q, state_d;
  logic [95:0]        tail_q;
  logic [NONCE_W-1:0] nonce_end_q;
  logic [255:0]       target_q;
  logic [NONCE_W-1:0] iss_nonce_q;
  logic [NONCE_W-1:0] nonce_nx;

  logic               load, advance, flush, win, done_d;
  logic               tag_vld, pend, hit;
  logic [NONCE_W-1:0] tag_nonce;

  nonce_delay_line #(.LAT(LAT), .NONCE_W(NONCE_W)) u_tags (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_vld    (msg_valid),
    .in_nonce  (iss_nonce_q),
    .out_vld   (tag_vld),
    .out_nonce (tag_nonce),
    .pend      (pend)
  );

  assign nonce_nx = iss_nonce_q + 32'd1;
  assign hit      = tag_vld && (bswap256(hash_in) <= target_q);
  assign busy     = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and per-cycle control; abort beats a hit, a hit beats the last issue.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    flush   = 1'b0;
    win     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SWEEP;
          load    = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
          flush   = 1'b1;
          done_d  = 1'b1;
        end else if (hit) begin
          state_d = IDLE;
          flush   = 1'b1;
          done_d  = 1'b1;
          win     = 1'b1;
        end else if (iss_nonce_q == nonce_end_q) begin
          state_d = DRAIN;
        end else begin
          advance = 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          flush   = 1'b1;
          done_d  = 1'b1;
        end else if (hit) begin
          state_d = IDLE;
          flush   = 1'b1;
          done_d  = 1'b1;
          win     = 1'b1;
        end else if (!pend) begin
          // The tag exiting now was just checked and nothing is behind it.
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched job, issue register and result; found is cleared at start, so an
  // aborted sweep always reports found=0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tail_q      <= '0;
      nonce_end_q <= '0;
      target_q    <= '0;
      iss_nonce_q <= '0;
      msg_block   <= '0;
      msg_valid   <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
    end else begin
      done <= done_d;
      if (load) begin
        tail_q      <= header_tail;
        nonce_end_q <= nonce_end;
        target_q    <= target;
        iss_nonce_q <= nonce_start;
        msg_block   <= build_tail_block(header_tail, nonce_start);
        msg_valid   <= 1'b1;
        found       <= 1'b0;
        found_nonce <= '0;
      end else if (advance) begin
        iss_nonce_q <= nonce_nx;
        msg_block   <= build_tail_block(tail_q, nonce_nx);
        msg_valid   <= 1'b1;
      end else begin
        msg_valid   <= 1'b0;
      end
      if (win) begin
        found       <= 1'b1;
        found_nonce <= tag_nonce;
      end
    end
  end

endmodule
